// File: rtl/locked_adder_pkg.sv
// Shared widths, scheduler state encoding and requester-id type for the
// locked-adder scheduler slice.
package locked_adder_pkg;

    localparam int KEY_W  = 32;
    localparam int OPND_W = 16;
    localparam int SUM_W  = 17;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RESP
    } sched_state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/locked_adder_scheduler_if.sv
// Key-provisioning, two-requester operand and response handshake bundle.
// The slave side is the scheduler. The master side drives keys and operands.
interface locked_adder_scheduler_if;
    import locked_adder_pkg::*;

    logic              key_wr_i;
    logic [KEY_W-1:0]  key_data_i;
    logic              key_ready_o;
    logic              key_valid_o;

    logic              req0_valid_i;
    logic              req1_valid_i;
    logic [OPND_W-1:0] req0_a_i;
    logic [OPND_W-1:0] req0_b_i;
    logic [OPND_W-1:0] req1_a_i;
    logic [OPND_W-1:0] req1_b_i;
    logic              req0_ready_o;
    logic              req1_ready_o;

    logic              rsp_valid_o;
    logic              rsp_ready_i;
    req_id_t           rsp_id_o;
    logic [SUM_W-1:0]  rsp_sum_o;
    logic              busy_o;

    modport slave (
        input  key_wr_i, key_data_i,
        input  req0_valid_i, req1_valid_i, req0_a_i, req0_b_i, req1_a_i, req1_b_i,
        input  rsp_ready_i,
        output key_ready_o, key_valid_o, req0_ready_o, req1_ready_o,
        output rsp_valid_o, rsp_id_o, rsp_sum_o, busy_o
    );

    modport master (
        output key_wr_i, key_data_i,
        output req0_valid_i, req1_valid_i, req0_a_i, req0_b_i, req1_a_i, req1_b_i,
        output rsp_ready_i,
        input  key_ready_o, key_valid_o, req0_ready_o, req1_ready_o,
        input  rsp_valid_o, rsp_id_o, rsp_sum_o, busy_o
    );

endinterface

// File: rtl/locked_adder_rr_arb.sv
// Two-way round-robin grant. When both requesters are valid, the grant goes to
// the requester that did not win last time.
module locked_adder_rr_arb
    import locked_adder_pkg::*;
(
    input  logic [1:0] valid,
    input  req_id_t    last_grant,
    input  logic       en,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (valid == 2'b11) begin
                grant = last_grant ? 2'b01 : 2'b10;
            end else begin
                grant = valid;
            end
        end
    end

endmodule

// File: rtl/xnor_based_carry_lookahead_adder16_xor_enc32.sv
// 16-bit two-level carry-lookahead adder locked with 32 key gates. The key
// gates sit on the propagate (key[15:0]) and generate (key[31:16]) wires.
module xnor_based_carry_lookahead_adder16_xor_enc32 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [31:0] key,
    output logic [16:0] sum
);
    // Where an unlock bit is 1 the gate is an XNOR, otherwise an XOR. Only the
    // unlock key makes every gate transparent.
    localparam logic [31:0] UNLOCK = 32'h094F5C00;

    logic [15:0] p;
    logic [15:0] g;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;
    logic        c;

    assign p = (a ^ b) ^ key[15:0]  ^ UNLOCK[15:0];
    assign g = (a & b) ^ key[31:16] ^ UNLOCK[31:16];

    always_comb begin
        gg  = '0;
        gp  = '1;
        gc  = '0;
        c   = 1'b0;
        sum = '0;
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < 4; i++) begin
                gg[j] = g[4*j+i] | (p[4*j+i] & gg[j]);
                gp[j] = gp[j] & p[4*j+i];
            end
        end
        // The group carries come from the lookahead. Each group then ripples
        // internally from its own carry-in.
        for (int j = 0; j < 4; j++) begin
            gc[j+1] = gg[j] | (gp[j] & gc[j]);
        end
        for (int j = 0; j < 4; j++) begin
            c = gc[j];
            for (int i = 0; i < 4; i++) begin
                sum[4*j+i] = p[4*j+i] ^ c;
                c          = g[4*j+i] | (p[4*j+i] & c);
            end
        end
        sum[16] = gc[4];
    end

endmodule

// File: rtl/locked_adder_scheduler.sv
// Shares one locked adder between two requesters. It accepts one operation,
// holds it on the adder for SETTLE_CYCLES edges, then returns the result.
module locked_adder_scheduler
    import locked_adder_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    locked_adder_scheduler_if.slave  bus
);

    // SETTLE_CYCLES must be 1 or more. The counter stays at least 1 bit wide.
    localparam int               CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    sched_state_t      state_q;
    sched_state_t      state_d;
    logic [KEY_W-1:0]  key_q;
    logic              key_valid_q;
    req_id_t           last_grant_q;
    req_id_t           id_q;
    logic [OPND_W-1:0] a_q;
    logic [OPND_W-1:0] b_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              rsp_valid_q;
    logic [SUM_W-1:0]  rsp_sum_q;
    logic [SUM_W-1:0]  adder_sum;

    logic              idle_open;
    logic              key_load;
    logic              arb_en;
    logic              accept;
    logic [1:0]        grant;

    // The handshake readies are gated by reset, so they read 0 while reset is applied.
    assign idle_open = (state_q == IDLE) && !rst_i;
    assign key_load  = idle_open && bus.key_wr_i;
    assign arb_en    = idle_open && key_valid_q && !bus.key_wr_i;
    assign accept    = |grant;

    locked_adder_rr_arb u_arb (
        .valid      ({bus.req1_valid_i, bus.req0_valid_i}),
        .last_grant (last_grant_q),
        .en         (arb_en),
        .grant      (grant)
    );

    xnor_based_carry_lookahead_adder16_xor_enc32 u_adder (
        .a   (a_q),
        .b   (b_q),
        .key (key_q),
        .sum (adder_sum)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)            state_d = SETTLE;
            SETTLE:  if (cnt_q == '0)       state_d = RESP;
            RESP:    if (bus.rsp_ready_i)   state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    // The adder inputs (key_q, a_q, b_q) change only on IDLE edges, so they
    // stay constant for the whole settle window.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            key_q        <= '0;
            key_valid_q  <= 1'b0;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            cnt_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_sum_q    <= '0;
        end else begin
            if (key_load) begin
                key_q       <= bus.key_data_i;
                key_valid_q <= 1'b1;
            end
            if (accept) begin
                a_q          <= grant[1] ? bus.req1_a_i : bus.req0_a_i;
                b_q          <= grant[1] ? bus.req1_b_i : bus.req0_b_i;
                id_q         <= grant[1];
                last_grant_q <= grant[1];
                cnt_q        <= CNT_LOAD;
            end
            if (state_q == SETTLE) begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end else begin
                    rsp_sum_q   <= adder_sum;
                    rsp_valid_q <= 1'b1;
                end
            end
            if ((state_q == RESP) && bus.rsp_ready_i) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.key_ready_o  = idle_open;
    assign bus.key_valid_o  = key_valid_q;
    assign bus.req0_ready_o = grant[0];
    assign bus.req1_ready_o = grant[1];
    assign bus.rsp_valid_o  = rsp_valid_q;
    assign bus.rsp_id_o     = id_q;
    assign bus.rsp_sum_o    = rsp_sum_q;
    assign bus.busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_locked_adder_scheduler.sv
// Scoreboard bench for locked_adder_scheduler. The reference model tracks the
// key, busy and round-robin state, and it expects a+b under the unlock key.
module tb_locked_adder_scheduler;
    import locked_adder_pkg::*;

    localparam int          S      = 2;
    localparam logic [31:0] KEY_OK = 32'h094F5C00;

    logic clk = 1'b0;
    logic rst = 1'b1;

    locked_adder_scheduler_if bus();

    locked_adder_scheduler #(.SETTLE_CYCLES(S)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [16:0] sum;
        bit          do_chk;
        int          acc_cyc;
    } exp_t;

    exp_t        q[$];
    int          acc_log[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    bit          model_busy = 1'b0;
    bit          key_loaded = 1'b0;
    bit          last_id = 1'b1;
    bit          busy_now;
    bit          en;
    bit          e0;
    bit          e1;
    logic [31:0] model_key = '0;
    bit          rsp_hold = 1'b0;
    logic [16:0] held_sum = '0;
    logic        held_id = 1'b0;
    logic [1:0]  acc_seen = 2'b00;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    endfunction

    function automatic void note_accept(input bit id, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        e.id      = id;
        e.sum     = {1'b0, a} + {1'b0, b};
        e.do_chk  = (model_key == KEY_OK);
        e.acc_cyc = cyc;
        q.push_back(e);
        acc_log.push_back(int'(id));
        last_id      = id;
        model_busy   = 1'b1;
        acc_seen[id] = 1'b1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: it checks the handshake rules every cycle and pops the scoreboard on a response.
    always @(negedge clk) begin
        acc_seen = 2'b00;
        if (rst) begin
            chk("rst_key_ready", 32'(bus.key_ready_o), 0);
            chk("rst_req_ready", 32'({bus.req1_ready_o, bus.req0_ready_o}), 0);
            q.delete();
            model_busy = 1'b0;
            key_loaded = 1'b0;
            model_key  = '0;
            last_id    = 1'b1;
            rsp_hold   = 1'b0;
        end else begin
            busy_now = model_busy;
            en = !busy_now && key_loaded && !bus.key_wr_i;
            e0 = en && bus.req0_valid_i && (!bus.req1_valid_i || last_id);
            e1 = en && bus.req1_valid_i && (!bus.req0_valid_i || !last_id);
            chk("req0_ready", 32'(bus.req0_ready_o), 32'(e0));
            chk("req1_ready", 32'(bus.req1_ready_o), 32'(e1));
            chk("key_ready", 32'(bus.key_ready_o), 32'(!busy_now));
            chk("key_valid", 32'(bus.key_valid_o), 32'(key_loaded));
            chk("busy", 32'(bus.busy_o), 32'(busy_now));
            if (bus.rsp_valid_o) begin
                if (q.size() == 0) begin
                    chk("rsp_spurious", 32'(bus.rsp_valid_o), 0);
                end else begin
                    if (rsp_hold) begin
                        chk("rsp_hold_sum", 32'(bus.rsp_sum_o), 32'(held_sum));
                        chk("rsp_hold_id", 32'(bus.rsp_id_o), 32'(held_id));
                    end else begin
                        chk("rsp_latency", cyc - q[0].acc_cyc, S + 1);
                    end
                    held_sum = bus.rsp_sum_o;
                    held_id  = bus.rsp_id_o;
                    if (bus.rsp_ready_i) begin
                        if (q[0].do_chk) chk("rsp_sum", 32'(bus.rsp_sum_o), 32'(q[0].sum));
                        chk("rsp_id", 32'(bus.rsp_id_o), 32'(q[0].id));
                        void'(q.pop_front());
                        model_busy = 1'b0;
                    end
                end
            end
            rsp_hold = bus.rsp_valid_o && !bus.rsp_ready_i;
            if (bus.key_wr_i && !busy_now) begin
                model_key  = bus.key_data_i;
                key_loaded = 1'b1;
            end
            if (bus.req0_valid_i && bus.req0_ready_o) note_accept(1'b0, bus.req0_a_i, bus.req0_b_i);
            else if (bus.req1_valid_i && bus.req1_ready_o) note_accept(1'b1, bus.req1_a_i, bus.req1_b_i);
        end
    end

    task automatic key_write(input logic [31:0] k);
        bus.key_wr_i   = 1'b1;
        bus.key_data_i = k;
        @(posedge clk); #1;
        bus.key_wr_i   = 1'b0;
    endtask

    // The request is raised and held until it is accepted or max_wait cycles pass.
    // waited is the number of cycles it took, or -1 if it was never accepted.
    task automatic do_req(input bit id, input logic [15:0] a, input logic [15:0] b,
                          input int max_wait, input bit with_key, output int waited);
        logic rdy;
        waited = -1;
        if (id) begin
            bus.req1_valid_i = 1'b1; bus.req1_a_i = a; bus.req1_b_i = b;
        end else begin
            bus.req0_valid_i = 1'b1; bus.req0_a_i = a; bus.req0_b_i = b;
        end
        if (with_key) begin
            bus.key_wr_i   = 1'b1;
            bus.key_data_i = KEY_OK;
        end
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk);
            rdy = id ? bus.req1_ready_o : bus.req0_ready_o;
            if (rdy) waited = i;
            @(posedge clk); #1;
            bus.key_wr_i = 1'b0;
            if (waited >= 0) break;
        end
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk); #1;
            done = (q.size() == 0) && !model_busy;
        end
        chk("drain", 32'(done), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        bus.key_wr_i = 1'b0; bus.key_data_i = '0;
        bus.req0_valid_i = 1'b0; bus.req1_valid_i = 1'b0;
        bus.req0_a_i = '0; bus.req0_b_i = '0; bus.req1_a_i = '0; bus.req1_b_i = '0;
        bus.rsp_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("reset_rsp_valid", 32'(bus.rsp_valid_o), 0);
        chk("reset_rsp_sum", 32'(bus.rsp_sum_o), 0);
        chk("reset_rsp_id", 32'(bus.rsp_id_o), 0);
        chk("reset_busy", 32'(bus.busy_o), 0);
        chk("reset_key_valid", 32'(bus.key_valid_o), 0);
        chk("reset_key_ready", 32'(bus.key_ready_o), 1);
        @(posedge clk); #1;

        // A request made before any key is loaded must not be accepted.
        do_req(1'b0, 16'h0000, 16'h0001, 20, 1'b0, w);
        chk("nokey_no_accept", w, -1);
        key_write(KEY_OK);
        do_req(1'b0, 16'h0000, 16'h0001, 20, 1'b0, w);
        chk("key_then_accept", w, 0);
        drain();

        // Basic sums, including one that produces a carry out.
        do_req(1'b0, 16'h29AF, 16'h7A1B, 20, 1'b0, w);
        chk("sum1_accept", w, 0);
        drain();
        do_req(1'b0, 16'h8943, 16'hFFFF, 20, 1'b0, w);
        chk("sum2_accept", w, 0);
        drain();

        // Backpressure: the response is held while a key write is attempted.
        bus.rsp_ready_i = 1'b0;
        do_req(1'b1, 16'h1234, 16'h4321, 20, 1'b0, w);
        repeat (S) begin @(posedge clk); #1; end
        key_write(KEY_OK ^ 32'h0000_0001);
        repeat (9) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("bp_rsp_valid", 32'(bus.rsp_valid_o), 1);
        chk("bp_key_ready", 32'(bus.key_ready_o), 0);
        @(posedge clk); #1;
        bus.rsp_ready_i = 1'b1;
        drain();
        do_req(1'b0, 16'hFFFF, 16'h0001, 20, 1'b0, w);
        drain();

        // A key write and a request in the same cycle: the key write wins, and
        // the request is accepted one cycle later.
        do_req(1'b1, 16'h00FF, 16'h0F00, 20, 1'b1, w);
        chk("kw_priority_wait", w, 1);
        drain();

        // Reset during SETTLE: no response comes out, and the key is cleared.
        do_req(1'b1, 16'h7777, 16'h1111, 20, 1'b0, w);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_rsp_valid", 32'(bus.rsp_valid_o), 0);
        chk("midrst_rsp_sum", 32'(bus.rsp_sum_o), 0);
        chk("midrst_rsp_id", 32'(bus.rsp_id_o), 0);
        chk("midrst_busy", 32'(bus.busy_o), 0);
        chk("midrst_key_valid", 32'(bus.key_valid_o), 0);
        @(posedge clk); #1;
        do_req(1'b1, 16'h0001, 16'h0001, 10, 1'b0, w);
        chk("midrst_no_accept", w, -1);
        key_write(KEY_OK);

        // Both requesters valid all the time: the grants alternate, starting with requester 0.
        acc_log.delete();
        bus.req0_a_i = 16'h5555; bus.req0_b_i = 16'hAAAA;
        bus.req1_a_i = 16'h1024; bus.req1_b_i = 16'h8192;
        bus.req0_valid_i = 1'b1; bus.req1_valid_i = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (acc_log.size() >= 4) break;
        end
        bus.req0_valid_i = 1'b0; bus.req1_valid_i = 1'b0;
        chk("rr_count", 32'(acc_log.size() >= 4), 1);
        if (acc_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("rr_order", acc_log[i], i % 2);
        end
        drain();

        // Random traffic: requests, response backpressure, and key writes. While
        // the scheduler is busy, the key writes carry wrong keys, which it must ignore.
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            if (!bus.req0_valid_i || acc_seen[0]) begin
                bus.req0_valid_i = 1'($urandom_range(0, 1));
                bus.req0_a_i = 16'($urandom); bus.req0_b_i = 16'($urandom);
            end
            if (!bus.req1_valid_i || acc_seen[1]) begin
                bus.req1_valid_i = 1'($urandom_range(0, 1));
                bus.req1_a_i = 16'($urandom); bus.req1_b_i = 16'($urandom);
            end
            if ($urandom_range(0, 7) == 0) begin
                bus.key_wr_i   = 1'b1;
                bus.key_data_i = model_busy ? (KEY_OK ^ ($urandom | 32'h1)) : KEY_OK;
            end else begin
                bus.key_wr_i = 1'b0;
            end
            bus.rsp_ready_i = ($urandom_range(0, 3) != 0);
        end
        bus.req0_valid_i = 1'b0; bus.req1_valid_i = 1'b0;
        bus.key_wr_i = 1'b0; bus.rsp_ready_i = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
